// File: rtl/iddmm_task_loader.sv
// Operand loader and result drainer for the IDDMM multiply engine.
// Handles request/grant, operand RAM writes, result capture and the result stream.
module iddmm_task_loader #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [K-1:0]      s_x,
   input  logic [K-1:0]      s_y,
   input  logic              s_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [K-1:0]      wr_x,
   output logic [K-1:0]      wr_y,
   output logic              task_req,
   input  logic              task_grant,
   output logic              finish_reg_flag,
   input  logic              task_end,
   input  logic [K-1:0]      task_res,
   output logic              m_valid,
   output logic [K-1:0]      m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              err
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      LOAD,
      FLAG,
      WAIT_RES,
      DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       wcnt_q, wcnt_d;
   logic [CW-1:0]       ccnt_q, ccnt_d;
   logic [CW-1:0]       rcnt_q, rcnt_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [K-1:0]        wr_x_q, wr_x_d;
   logic [K-1:0]        wr_y_q, wr_y_d;
   logic                fin_q, fin_d;
   logic                err_q, err_d;
   logic                cap_we;
   logic [K-1:0]        res_mem_q [N];

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      ccnt_d    = ccnt_q;
      rcnt_d    = rcnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_x_d    = wr_x_q;
      wr_y_d    = wr_y_q;
      fin_d     = (state_q == FLAG);
      err_d     = err_q;
      cap_we    = 1'b0;
      s_ready   = 1'b0;
      task_req  = 1'b0;
      m_valid   = 1'b0;
      m_data    = '0;
      m_last    = 1'b0;

      // A result word outside WAIT_RES is a protocol error and never stored.
      if (task_end && (state_q != WAIT_RES)) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            wcnt_d = '0;
            ccnt_d = '0;
            rcnt_d = '0;
            if (s_valid) begin
               state_d = REQ;
            end
         end
         REQ: begin
            task_req = 1'b1;
            if (task_grant) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = wcnt_q[ADDR_W-1:0];
               wr_x_d    = s_x;
               wr_y_d    = s_y;
               wcnt_d    = wcnt_q + CW'(1);
               // The word count ends the load; s_last is only cross-checked.
               if (s_last != (wcnt_q == LAST)) begin
                  err_d = 1'b1;
               end
               if (wcnt_q == LAST) begin
                  state_d = FLAG;
               end
            end
         end
         FLAG: begin
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (task_end) begin
               cap_we = 1'b1;
               ccnt_d = ccnt_q + CW'(1);
               if (ccnt_q == LAST) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            m_valid = 1'b1;
            m_data  = res_mem_q[rcnt_q[ADDR_W-1:0]];
            m_last  = (rcnt_q == LAST);
            if (m_ready) begin
               rcnt_d = rcnt_q + CW'(1);
               if (rcnt_q == LAST) begin
                  state_d = IDLE;
                  wcnt_d  = '0;
                  ccnt_d  = '0;
                  rcnt_d  = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         ccnt_q    <= '0;
         rcnt_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_x_q    <= '0;
         wr_y_q    <= '0;
         fin_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         ccnt_q    <= ccnt_d;
         rcnt_q    <= rcnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_x_q    <= wr_x_d;
         wr_y_q    <= wr_y_d;
         fin_q     <= fin_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cap_we) begin
         res_mem_q[ccnt_q[ADDR_W-1:0]] <= task_res;
      end
   end

   assign wr_en           = wr_en_q;
   assign wr_addr         = wr_addr_q;
   assign wr_x            = wr_x_q;
   assign wr_y            = wr_y_q;
   assign finish_reg_flag = fin_q;
   assign err             = err_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_iddmm_task_loader.sv
// Directed scoreboard bench for iddmm_task_loader with K=8, N=4.
module tb_iddmm_task_loader;

   logic       clk;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_x;
   logic [7:0] s_y;
   logic       s_last;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_x;
   logic [7:0] wr_y;
   logic       task_req;
   logic       task_grant;
   logic       finish_reg_flag;
   logic       task_end;
   logic [7:0] task_res;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready;
   logic       busy;
   logic       err;

   int vectors = 0;
   int miscompares = 0;

   logic [23:0] wq[$];
   logic [7:0]  rq[$];
   logic        fin_exp = 1'b0;
   int          rd_idx = 0;
   logic        stall_prev = 1'b0;

   iddmm_task_loader #(.K(8), .N(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .task_req(task_req), .task_grant(task_grant), .finish_reg_flag(finish_reg_flag),
      .task_end(task_end), .task_res(task_res),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready), 0);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_task_req"}, 32'(task_req), 0);
      check({tag, "_finish"}, 32'(finish_reg_flag), 0);
      check({tag, "_m_valid"}, 32'(m_valid), 0);
      check({tag, "_m_last"}, 32'(m_last), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_wr_x"}, 32'(wr_x), 0);
      check({tag, "_wr_y"}, 32'(wr_y), 0);
      check({tag, "_m_data"}, 32'(m_data), 0);
   endtask

   // Output monitor: pops expected writes/results and checks stream rules.
   always @(negedge clk) begin
      logic [23:0] e;
      logic        fin_next;
      if (!rst_n) begin
         wq.delete();
         rq.delete();
         fin_exp    = 1'b0;
         rd_idx     = 0;
         stall_prev = 1'b0;
      end else begin
         fin_next = 1'b0;
         if (wr_en) begin
            if (wq.size() == 0) begin
               check("wr_unexpected", 32'(wr_en), 0);
            end else begin
               e = wq.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e[23:16]));
               check("wr_x", 32'(wr_x), 32'(e[15:8]));
               check("wr_y", 32'(wr_y), 32'(e[7:0]));
               fin_next = (e[23:16] == 8'd3);
            end
         end
         check("finish_flag", 32'(finish_reg_flag), 32'(fin_exp));
         fin_exp = fin_next;
         if (stall_prev) begin
            check("m_valid_hold", 32'(m_valid), 1);
         end
         if (m_valid) begin
            if (rq.size() == 0) begin
               check("m_unexpected", 32'(m_valid), 0);
            end else begin
               check("m_data", 32'(m_data), 32'(rq[0]));
               check("m_last", 32'(m_last), 32'(rd_idx == 3));
               if (m_ready) begin
                  void'(rq.pop_front());
                  rd_idx = (rd_idx + 1) % 4;
               end
            end
         end
         stall_prev = m_valid && !m_ready;
      end
   end

   task automatic do_load(input logic [7:0] seed, input int last_pos, input bit stray);
      int  sent = 0;
      int  req_cyc = 0;
      int  cyc = 0;
      bit  hs;
      logic [7:0] xv;
      s_valid = 1'b1;
      while (sent < 4 && cyc < 200) begin
         xv         = (8'h11 * 8'(sent + 1)) ^ seed;
         s_x        = xv;
         s_y        = ~xv;
         s_last     = (sent == last_pos);
         task_grant = (req_cyc >= 2) && task_req;
         task_end   = stray && (sent == 2);
         task_res   = 8'hEE;
         @(negedge clk);
         hs = s_valid && s_ready;
         if (hs) wq.push_back({8'(sent), xv, ~xv});
         if (task_req) req_cyc++;
         @(posedge clk); #1;
         if (hs) sent++;
         cyc++;
      end
      s_valid    = 1'b0;
      s_last     = 1'b0;
      task_grant = 1'b0;
      task_end   = 1'b0;
      if (cyc >= 200) check("load_timeout", 32'(sent), 4);
   endtask

   task automatic do_results(input logic [7:0] base, input logic [7:0] pat, input int plen);
      int k = 0;
      @(posedge clk); #1;
      for (int j = 0; j < plen; j++) begin
         task_end = pat[j];
         if (pat[j]) begin
            task_res = base + 8'(k);
            rq.push_back(base + 8'(k));
            k++;
         end
         @(posedge clk); #1;
      end
      task_end = 1'b0;
   endtask

   task automatic do_drain(input logic [3:0] rpat);
      int cyc = 0;
      while (rq.size() > 0 && cyc < 100) begin
         m_ready = rpat[cyc % 4];
         @(posedge clk); #1;
         cyc++;
      end
      m_ready = 1'b0;
      if (cyc >= 100) check("drain_timeout", 32'(rq.size()), 0);
      check("busy_after_drain", 32'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_last = 1'b0;
      task_grant = 1'b0; task_end = 1'b0; task_res = '0; m_ready = 1'b0;
      #3;
      check_all_zero("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Stray grant in IDLE must not start anything.
      task_grant = 1'b1;
      @(posedge clk); #1;
      task_grant = 1'b0;
      check("idle_grant_busy", 32'(busy), 0);
      check("idle_grant_req", 32'(task_req), 0);

      // Basic task: consecutive results, no backpressure.
      do_load(8'h00, 3, 1'b0);
      check("load_a_err", 32'(err), 0);
      do_results(8'hA0, 8'b0000_1111, 4);
      check("a_drain_entered", 32'(m_valid), 1);
      do_drain(4'b1111);

      // Gapped task_end and m_ready backpressure 1,0,0,1.
      do_load(8'h5A, 3, 1'b0);
      do_results(8'hB0, 8'b0010_1101, 6);
      check("b_drain_entered", 32'(m_valid), 1);
      do_drain(4'b1001);
      check("b_err", 32'(err), 0);

      // Early s_last plus stray task_end during LOAD.
      do_load(8'h33, 1, 1'b1);
      check("c_err_set", 32'(err), 1);
      do_results(8'hC0, 8'b0000_1111, 4);
      do_drain(4'b1101);
      check("c_err_sticky", 32'(err), 1);

      // Reset after two captures abandons the task.
      do_load(8'h0F, 3, 1'b0);
      do_results(8'hD0, 8'b0000_0011, 2);
      check("d_busy_before_rst", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midtask_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_m_valid", 32'(m_valid), 0);

      do_load(8'hC3, 3, 1'b0);
      do_results(8'hE0, 8'b0000_1111, 4);
      do_drain(4'b1011);
      check("e_err", 32'(err), 0);

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
